// File: rtl/uart_tx_buffered_if.sv
// Byte handshake between a producer and the buffered UART transmitter.
// Build option: none (the UART_TX_PARITY_EN option lives in uart_tx_buffered.sv).
//   tx_data   byte to queue            (master -> slave)
//   tx_valid  tx_data valid            (master -> slave)
//   tx_ready  FIFO can accept a byte   (slave -> master)
interface uart_tx_buffered_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_tx_buffered.sv
// FIFO-buffered UART transmitter: 8N1 (or 8E1) framing, LSB first, idle-high line.
// Bytes arrive over a valid/ready handshake, are queued in a FIFO and are
// serialised back-to-back without idle gaps between queued frames.
// Build option: `define UART_TX_PARITY_EN inserts an even-parity bit after the data.
// Ports:
//   sys_clk     system clock, rising edge
//   sys_rst_n   asynchronous active-low reset
//   tx          byte handshake (slave side): tx_data, tx_valid, tx_ready (= !full)
//   uart_txd    serial output, registered
//   tx_busy     a frame is on the line, registered alongside uart_txd
//   fifo_level  bytes queued, 0..FIFO_DEPTH
module uart_tx_buffered #(
  parameter int unsigned CLK_FREQ   = 50_000_000,
  parameter int unsigned UART_BPS   = 115_200,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                          sys_clk,
  input  logic                          sys_rst_n,
  uart_tx_buffered_if.slave             tx,
  output logic                          uart_txd,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int unsigned AW      = $clog2(FIFO_DEPTH);
  localparam int unsigned LW      = AW + 1;
  localparam int unsigned BPS_CNT = CLK_FREQ / UART_BPS;
  localparam int unsigned CW      = (BPS_CNT > 1) ? $clog2(BPS_CNT) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  // FIFO storage and bookkeeping
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] level;
  logic [7:0]    rd_data;
  logic          push;
  logic          pop;

  // Serialiser
  state_t        state;
  logic [CW-1:0] bit_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic          bit_last;
`ifdef UART_TX_PARITY_EN
  logic          parity_bit;
`endif

  assign tx.tx_ready = (level != LW'(FIFO_DEPTH));
  assign fifo_level  = level;
  assign rd_data     = mem[rd_ptr];
  assign bit_last    = (bit_cnt == CW'(BPS_CNT - 1));
  assign push        = tx.tx_valid && tx.tx_ready;
  // Pop only when the line is free: from IDLE, or on the final STOP clock so frames abut.
  assign pop         = (level != '0) &&
                       ((state == S_IDLE) || ((state == S_STOP) && bit_last));

  // Byte storage: not reset, the pointers define what is valid.
  always_ff @(posedge sys_clk) begin
    if (push) mem[wr_ptr] <= tx.tx_data;
  end

  // Pointers wrap naturally; the level counter alone decides full/empty.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  // Frame sequencer; line outputs are registered from the current state, one clock behind it.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state    <= S_IDLE;
      bit_cnt  <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      uart_txd <= 1'b1;
      tx_busy  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else begin
      case (state)
        S_START: uart_txd <= 1'b0;
        S_DATA:  uart_txd <= shift[0];
`ifdef UART_TX_PARITY_EN
        S_PARITY: uart_txd <= parity_bit;
`endif
        default: uart_txd <= 1'b1;
      endcase
      tx_busy <= (state != S_IDLE);

      case (state)
        S_IDLE: begin
          bit_cnt <= '0;
          if (pop) begin
            shift <= rd_data;
`ifdef UART_TX_PARITY_EN
            parity_bit <= ^rd_data;
`endif
            state <= S_START;
          end
        end

        S_START: begin
          if (bit_last) begin
            bit_cnt <= '0;
            bit_idx <= '0;
            state   <= S_DATA;
          end else begin
            bit_cnt <= bit_cnt + CW'(1);
          end
        end

        S_DATA: begin
          if (bit_last) begin
            bit_cnt <= '0;
            shift   <= shift >> 1;
            if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              state <= S_PARITY;
`else
              state <= S_STOP;
`endif
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            bit_cnt <= bit_cnt + CW'(1);
          end
        end

`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          if (bit_last) begin
            bit_cnt <= '0;
            state   <= S_STOP;
          end else begin
            bit_cnt <= bit_cnt + CW'(1);
          end
        end
`endif

        S_STOP: begin
          if (bit_last) begin
            bit_cnt <= '0;
            if (pop) begin
              shift <= rd_data;
`ifdef UART_TX_PARITY_EN
              parity_bit <= ^rd_data;
`endif
              state <= S_START;
            end else begin
              state <= S_IDLE;
            end
          end else begin
            bit_cnt <= bit_cnt + CW'(1);
          end
        end

        default: begin
          bit_cnt <= '0;
          state   <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Self-checking bench for uart_tx_buffered: accepted bytes are queued as
// expected frames; a line monitor decodes uart_txd/tx_busy clock by clock
// against an ideal frame built from the byte.
`timescale 1ns/1ps
module tb_uart_tx_buffered;
  localparam int unsigned CLK_FREQ   = 1000;
  localparam int unsigned UART_BPS   = 100;
  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned BPS        = CLK_FREQ / UART_BPS;
`ifdef UART_TX_PARITY_EN
  localparam int unsigned NBITS = 11;
`else
  localparam int unsigned NBITS = 10;
`endif
  localparam int unsigned FRAME = NBITS * BPS;
  localparam int unsigned LW    = $clog2(FIFO_DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          txd;
  logic          busy;
  logic [LW-1:0] level;

  uart_tx_buffered_if tx_if ();

  uart_tx_buffered #(
    .CLK_FREQ  (CLK_FREQ),
    .UART_BPS  (UART_BPS),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .sys_clk   (clk),
    .sys_rst_n (rst_n),
    .tx        (tx_if),
    .uart_txd  (txd),
    .tx_busy   (busy),
    .fifo_level(level)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  exp_q[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Ideal line waveform, LSB = first bit on the wire.
  function automatic logic [NBITS-1:0] make_frame(input logic [7:0] b);
`ifdef UART_TX_PARITY_EN
    return {1'b1, ^b, b, 1'b0};
`else
    return {1'b1, b, 1'b0};
`endif
  endfunction

  // Line monitor
  logic [NBITS-1:0] fbits;
  logic [NBITS-1:0] fshift;
  logic [7:0]       fbyte;
  bit               in_frame = 1'b0;
  int unsigned      fpos = 0;
  int unsigned      frame_bad = 0;
  int unsigned      busy_run = 0;
  int unsigned      last_run = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      in_frame = 1'b0;
      exp_q.delete();
      busy_run = 0;
    end else begin
      if (busy) busy_run++;
      else if (busy_run != 0) begin
        last_run = busy_run;
        busy_run = 0;
      end
      if (!in_frame && txd == 1'b0) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_frame", 1, 0);
          fbyte = 8'h00;
        end else begin
          fbyte = exp_q.pop_front();
        end
        fbits     = make_frame(fbyte);
        in_frame  = 1'b1;
        fpos      = 0;
        frame_bad = 0;
      end
      if (in_frame) begin
        fshift = fbits >> (fpos / BPS);
        if (txd !== fshift[0] || busy !== 1'b1) frame_bad++;
        fpos++;
        if (fpos == FRAME) begin
          in_frame = 1'b0;
          checks++;
          if (frame_bad != 0) begin
            errors++;
            $display("FAIL frame 0x%02h: %0d wrong line samples, expected 0", fbyte, frame_bad);
          end
        end
      end else begin
        chk("idle_busy", int'(busy), 0);
      end
    end
  end

  // Offer a byte from a negedge, hold until accepted; returns at the negedge after the accept edge.
  task automatic send(input logic [7:0] b, output int unsigned acc);
    int unsigned n;
    n = 0;
    tx_if.tx_data  = b;
    tx_if.tx_valid = 1'b1;
    while (tx_if.tx_ready !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) begin
      chk("send_timeout", 0, 1);
      tx_if.tx_valid = 1'b0;
      acc = cyc;
    end else begin
      exp_q.push_back(b);
      @(negedge clk);
      acc = cyc;
    end
  endtask

  task automatic wait_idle(input int unsigned max);
    int unsigned n;
    n = 0;
    while (!(exp_q.size() == 0 && !in_frame && busy == 1'b0 && txd == 1'b1) && n < max) begin
      @(negedge clk);
      n++;
    end
    if (n >= max) chk("idle_timeout", 0, 1);
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned acc;
    int unsigned t;
    int unsigned k;
    int unsigned lows;
    int unsigned gap;
    logic [7:0]  burst [5];
    logic [7:0]  rb;

    burst[0] = 8'h00; burst[1] = 8'hFF; burst[2] = 8'h55; burst[3] = 8'hAA; burst[4] = 8'h0F;
    tx_if.tx_valid = 1'b0;
    tx_if.tx_data  = 8'h00;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_txd", int'(txd), 1);
    chk("reset_busy", int'(busy), 0);
    chk("reset_ready", int'(tx_if.tx_ready), 1);
    chk("reset_level", int'(level), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single byte: start bit two clocks after accept, busy for exactly one frame.
    send(8'hA5, acc);
    tx_if.tx_valid = 1'b0;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (txd !== 1'b0 && k < 20);
    chk("start_latency", int'(k), 2);
    wait_idle(1000);
    chk("single_busy_run", int'(last_run), int'(FRAME));

    send(8'h07, acc);
    tx_if.tx_valid = 1'b0;
    wait_idle(1000);
    chk("single07_busy_run", int'(last_run), int'(FRAME));

    // Burst with tx_valid held, then a push attempt while full.
    foreach (burst[i]) send(burst[i], acc);
    chk("burst_full_level", int'(level), int'(FIFO_DEPTH));
    chk("burst_full_ready", int'(tx_if.tx_ready), 0);
    tx_if.tx_data = 8'h77;
    repeat (5) begin
      @(negedge clk);
      chk("full_hold_level", int'(level), int'(FIFO_DEPTH));
      chk("full_hold_ready", int'(tx_if.tx_ready), 0);
    end
    tx_if.tx_valid = 1'b0;
    wait_idle(5000);
    chk("burst_busy_run", int'(last_run), int'(5 * FRAME));

    // Push on the same edge as the STOP-end pop, at level 2.
    send(8'h12, acc);
    send(8'h34, t);
    send(8'h56, t);
    tx_if.tx_valid = 1'b0;
    while (cyc < acc + FRAME) @(negedge clk);
    chk("pre_pushpop_level", int'(level), 2);
    send(8'h78, t);
    tx_if.tx_valid = 1'b0;
    chk("pushpop_edge", int'(t - acc), int'(FRAME + 1));
    chk("pushpop_level", int'(level), 2);
    wait_idle(5000);
    chk("pushpop_busy_run", int'(last_run), int'(4 * FRAME));

    // Reset in the middle of a data bit with two bytes still queued.
    send(8'h3C, acc);
    send(8'h11, t);
    send(8'h22, t);
    tx_if.tx_valid = 1'b0;
    while (cyc < acc + 4 * BPS) @(negedge clk);
    chk("pre_reset_level", int'(level), 2);
    chk("pre_reset_busy", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_txd", int'(txd), 1);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_level", int'(level), 0);
    chk("midrst_ready", int'(tx_if.tx_ready), 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    lows = 0;
    repeat (3 * FRAME) begin
      @(negedge clk);
      if (txd !== 1'b1 || busy !== 1'b0) lows++;
    end
    chk("post_reset_quiet", int'(lows), 0);
    send(8'h5A, acc);
    tx_if.tx_valid = 1'b0;
    wait_idle(1000);

    // Random bytes with random producer gaps.
    for (int i = 0; i < 30; i++) begin
      rb = 8'($urandom_range(0, 255));
      send(rb, acc);
      gap = ($urandom_range(0, 9) == 0) ? FRAME + 20 : $urandom_range(0, 3);
      if (gap != 0) begin
        tx_if.tx_valid = 1'b0;
        repeat (gap) @(negedge clk);
      end
    end
    tx_if.tx_valid = 1'b0;
    wait_idle(20000);
    chk("final_queue_empty", exp_q.size(), 0);
    chk("final_level", int'(level), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
